// File: rtl/vote_collector.sv
// Assembles LANES_PER_BEAT-wide predicate/active beats into one full-warp vote request.
// Latency 1 cycle after the final beat; in_ready drops only while a held request is back-pressured.
// Optional macro VOTE_COLLECT_PERF_EN adds perf_issued / perf_errors counters.
package pkg_opengpu;
    localparam int WARP_SIZE = 32;
    typedef enum logic [1:0] {
        VOTE_ALL = 2'd0,
        VOTE_ANY = 2'd1,
        VOTE_UNI = 2'd2,
        VOTE_BAL = 2'd3
    } vote_op_t;
endpackage

module vote_collector
    import pkg_opengpu::vote_op_t;
#(
    parameter int WARP_SIZE      = pkg_opengpu::WARP_SIZE,
    parameter int LANES_PER_BEAT = 8,
    parameter int WARP_ID_WIDTH  = 5,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic [LANES_PER_BEAT-1:0] in_pred,
    input  logic [LANES_PER_BEAT-1:0] in_mask,
    input  vote_op_t                  in_vote_op,
    input  logic [WARP_ID_WIDTH-1:0]  in_warp_id,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WARP_SIZE-1:0]      out_predicate,
    output logic [WARP_SIZE-1:0]      out_active_mask,
    output vote_op_t                  out_vote_op,
    output logic [WARP_ID_WIDTH-1:0]  out_warp_id,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      proto_err
`ifdef VOTE_COLLECT_PERF_EN
    ,
    output logic [31:0]               perf_issued,
    output logic [31:0]               perf_errors
`endif
);
    localparam int NUM_BEATS = WARP_SIZE / LANES_PER_BEAT;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    if (LANES_PER_BEAT <= 0 || (WARP_SIZE % LANES_PER_BEAT) != 0) begin : g_bad_cfg
        $error("vote_collector: LANES_PER_BEAT must divide WARP_SIZE");
    end

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [WARP_SIZE-1:0]      pred_q, pred_d, mask_q, mask_d;
    vote_op_t                  op_q, op_d;
    logic [WARP_ID_WIDTH-1:0]  warp_q, warp_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      err_q, err_d;
    logic                      accept, start, write_beat;

    assign accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // A first beat in any state starts a new instruction; a stray beat is dropped and flagged.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        start      = 1'b0;
        write_beat = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (in_first) start = 1'b1;
                        else          err_d = 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        if (in_first) begin
                            start = 1'b1;
                            err_d = 1'b1;
                        end else begin
                            write_beat = 1'b1;
                            if (cnt_q == CNT_W'(NUM_BEATS - 1)) begin
                                state_d = S_HOLD;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) state_d = S_IDLE;
                    if (accept) begin
                        if (in_first) start = 1'b1;
                        else          err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (start) begin
                if (NUM_BEATS == 1) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    state_d = S_COLLECT;
                    cnt_d   = CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        in_ready  = (state_q != S_HOLD) || out_ready;
        out_valid = (state_q == S_HOLD);
        proto_err = err_q;
    end

    // Beat 0 clears the stale lanes of the previous instruction.
    always_comb begin
        pred_d = pred_q;
        mask_d = mask_q;
        op_d   = op_q;
        warp_d = warp_q;
        rd_d   = rd_q;
        if (start) begin
            pred_d                       = '0;
            mask_d                       = '0;
            pred_d[LANES_PER_BEAT-1:0]   = in_pred;
            mask_d[LANES_PER_BEAT-1:0]   = in_mask;
            op_d                         = in_vote_op;
            warp_d                       = in_warp_id;
            rd_d                         = in_rd;
        end else if (write_beat) begin
            for (int b = 0; b < NUM_BEATS; b++) begin
                if (cnt_q == CNT_W'(b)) begin
                    pred_d[b*LANES_PER_BEAT +: LANES_PER_BEAT] = in_pred;
                    mask_d[b*LANES_PER_BEAT +: LANES_PER_BEAT] = in_mask;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q <= '0;
            mask_q <= '0;
            op_q   <= pkg_opengpu::VOTE_ALL;
            warp_q <= '0;
            rd_q   <= '0;
        end else begin
            pred_q <= pred_d;
            mask_q <= mask_d;
            op_q   <= op_d;
            warp_q <= warp_d;
            rd_q   <= rd_d;
        end
    end

    assign out_predicate   = pred_q;
    assign out_active_mask = mask_q;
    assign out_vote_op     = op_q;
    assign out_warp_id     = warp_q;
    assign out_rd          = rd_q;

`ifdef VOTE_COLLECT_PERF_EN
    logic [31:0] perf_issued_q, perf_errors_q;

    // Survive flush so software sees lifetime totals.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_errors_q <= '0;
        end else begin
            if (out_valid && out_ready) perf_issued_q <= perf_issued_q + 32'd1;
            if (err_q)                  perf_errors_q <= perf_errors_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_errors = perf_errors_q;
`endif

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector: stimulus pushes expected requests, a negedge monitor pops and checks them.
module tb_vote_collector;
    import pkg_opengpu::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_first;
    logic [7:0]  in_pred, in_mask;
    vote_op_t    in_vote_op, out_vote_op;
    logic [4:0]  in_warp_id, in_rd, out_warp_id, out_rd;
    logic        out_valid, out_ready, proto_err;
    logic [31:0] out_predicate, out_active_mask;
`ifdef VOTE_COLLECT_PERF_EN
    logic [31:0] perf_issued, perf_errors;
`endif

    always #5 clk = ~clk;

    vote_collector dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_pred(in_pred), .in_mask(in_mask), .in_vote_op(in_vote_op),
        .in_warp_id(in_warp_id), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_predicate(out_predicate), .out_active_mask(out_active_mask),
        .out_vote_op(out_vote_op), .out_warp_id(out_warp_id), .out_rd(out_rd),
        .proto_err(proto_err)
`ifdef VOTE_COLLECT_PERF_EN
        , .perf_issued(perf_issued), .perf_errors(perf_errors)
`endif
    );

    typedef struct {
        logic [31:0] pred;
        logic [31:0] mask;
        vote_op_t    op;
        logic [4:0]  warp;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   err_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic [7:0] p, input logic [7:0] m,
                         input vote_op_t op, input logic [4:0] w, input logic [4:0] r);
        int n;
        in_valid = 1'b1; in_first = f; in_pred = p; in_mask = m;
        in_vote_op = op; in_warp_id = w; in_rd = r;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: in_ready stuck at %0b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (proto_err) err_seen++;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: pred=%h mask=%h, no request expected",
                             out_predicate, out_active_mask);
                end else begin : pop
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_predicate !== e.pred || out_active_mask !== e.mask ||
                        out_vote_op !== e.op || out_warp_id !== e.warp || out_rd !== e.rd) begin
                        errors++;
                        $display("FAIL request: got pred=%h mask=%h op=%0d warp=%0d rd=%0d required pred=%h mask=%h op=%0d warp=%0d rd=%0d",
                                 out_predicate, out_active_mask, out_vote_op, out_warp_id, out_rd,
                                 e.pred, e.mask, e.op, e.warp, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_first = 1'b0;
        in_pred = '0; in_mask = '0; in_vote_op = VOTE_ALL; in_warp_id = '0; in_rd = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_proto_err", proto_err, 0);
        chk("reset_pred", out_predicate, 0);
        chk("reset_op", out_vote_op, VOTE_ALL);
        rst = 1'b0;

        // Basic 4-beat instruction; op/warp/rd on later beats must be ignored.
        exp_q.push_back('{32'hA5000FFF, 32'hFFFFFFFF, VOTE_BAL, 5'd3, 5'd7});
        drive(1, 8'hFF, 8'hFF, VOTE_BAL, 5'd3, 5'd7);
        drive(0, 8'h0F, 8'hFF, VOTE_ANY, 5'd0, 5'd0);
        drive(0, 8'h00, 8'hFF, VOTE_ANY, 5'd0, 5'd0);
        drive(0, 8'hA5, 8'hFF, VOTE_ANY, 5'd0, 5'd0);
        chk("t1_valid", out_valid, 1);
        chk("t1_pred", out_predicate, 32'hA5000FFF);
        chk("t1_warp", out_warp_id, 3);
        tick();
        chk("t1_valid_drop", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        exp_q.push_back('{32'h44332211, 32'h01FF0FF0, VOTE_ANY, 5'd9, 5'd12});
        drive(1, 8'h11, 8'hF0, VOTE_ANY, 5'd9, 5'd12);
        drive(0, 8'h22, 8'h0F, VOTE_ALL, 5'd1, 5'd1);
        drive(0, 8'h33, 8'hFF, VOTE_ALL, 5'd1, 5'd1);
        drive(0, 8'h44, 8'h01, VOTE_ALL, 5'd1, 5'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_pred", out_predicate, 32'h44332211);
            chk("bp_mask", out_active_mask, 32'h01FF0FF0);
        end
        tick();

        // Release overlapping with next first beat, which then gets restarted.
        out_ready = 1'b1;
        exp_q.push_back('{32'h04030201, 32'hFFFFFFFF, VOTE_UNI, 5'd4, 5'd2});
        drive(1, 8'hAA, 8'hFF, VOTE_ANY, 5'd1, 5'd1);
        chk("overlap_valid_drop", out_valid, 0);
        drive(0, 8'hBB, 8'hFF, VOTE_ANY, 5'd1, 5'd1);
        drive(1, 8'h01, 8'hFF, VOTE_UNI, 5'd4, 5'd2);
        chk("restart_err", proto_err, 1);
        drive(0, 8'h02, 8'hFF, VOTE_ALL, 5'd0, 5'd0);
        chk("restart_err_pulse", proto_err, 0);
        drive(0, 8'h03, 8'hFF, VOTE_ALL, 5'd0, 5'd0);
        drive(0, 8'h04, 8'hFF, VOTE_ALL, 5'd0, 5'd0);
        chk("restart_valid", out_valid, 1);
        tick();

        // Stray beat in IDLE
        drive(0, 8'h55, 8'hFF, VOTE_BAL, 5'd7, 5'd7);
        chk("stray_err", proto_err, 1);
        chk("stray_no_valid", out_valid, 0);
        exp_q.push_back('{32'h10204080, 32'h0F0F0F0F, VOTE_ALL, 5'd31, 5'd31});
        drive(1, 8'h80, 8'h0F, VOTE_ALL, 5'd31, 5'd31);
        drive(0, 8'h40, 8'h0F, VOTE_BAL, 5'd0, 5'd0);
        drive(0, 8'h20, 8'h0F, VOTE_BAL, 5'd0, 5'd0);
        drive(0, 8'h10, 8'h0F, VOTE_BAL, 5'd0, 5'd0);
        chk("stray_next_valid", out_valid, 1);
        tick();

        // Flush after beat 2, with a same-cycle beat that must be ignored.
        drive(1, 8'h01, 8'hFF, VOTE_ANY, 5'd2, 5'd2);
        drive(0, 8'h02, 8'hFF, VOTE_ANY, 5'd2, 5'd2);
        drive(0, 8'h03, 8'hFF, VOTE_ANY, 5'd2, 5'd2);
        flush = 1'b1; in_valid = 1'b1; in_first = 1'b0; in_pred = 8'h04;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_collect_valid", out_valid, 0);
        tick();
        chk("flush_collect_valid2", out_valid, 0);
        drive(0, 8'h66, 8'hFF, VOTE_ANY, 5'd0, 5'd0);
        chk("flush_collect_idle", proto_err, 1);

        // Flush during HOLD
        out_ready = 1'b0;
        drive(1, 8'h01, 8'h01, VOTE_BAL, 5'd5, 5'd5);
        drive(0, 8'h02, 8'h02, VOTE_BAL, 5'd5, 5'd5);
        drive(0, 8'h03, 8'h03, VOTE_BAL, 5'd5, 5'd5);
        drive(0, 8'h04, 8'h04, VOTE_BAL, 5'd5, 5'd5);
        chk("hold_valid", out_valid, 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_hold_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_hold_quiet", out_valid, 0);

        exp_q.push_back('{32'hDDCCBBAA, 32'h00FF00FF, VOTE_UNI, 5'd17, 5'd30});
        drive(1, 8'hAA, 8'hFF, VOTE_UNI, 5'd17, 5'd30);
        drive(0, 8'hBB, 8'h00, VOTE_ALL, 5'd0, 5'd0);
        drive(0, 8'hCC, 8'hFF, VOTE_ALL, 5'd0, 5'd0);
        drive(0, 8'hDD, 8'h00, VOTE_ALL, 5'd0, 5'd0);
        tick();
        tick();
        chk("err_pulse_count", err_seen, 3);
        chk("scoreboard_drained", exp_q.size(), 0);
`ifdef VOTE_COLLECT_PERF_EN
        chk("perf_issued", perf_issued, 5);
        chk("perf_errors", perf_errors, 3);
`endif

        // Reset mid-COLLECT with a beat presented.
        drive(1, 8'hEE, 8'hFF, VOTE_BAL, 5'd6, 5'd9);
        drive(0, 8'hEE, 8'hFF, VOTE_BAL, 5'd6, 5'd9);
        in_valid = 1'b1; in_first = 1'b0; in_pred = 8'h77;
        rst = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_err", proto_err, 0);
        chk("rst_pred", out_predicate, 0);
        chk("rst_mask", out_active_mask, 0);
        chk("rst_op", out_vote_op, VOTE_ALL);
        chk("rst_warp", out_warp_id, 0);
        chk("rst_rd", out_rd, 0);
`ifdef VOTE_COLLECT_PERF_EN
        chk("rst_perf_issued", perf_issued, 0);
        chk("rst_perf_errors", perf_errors, 0);
`endif
        rst = 1'b0;
        tick();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vote_collector.md
Name: vote_collector

Overview:
- Upstream feeder for the warp vote unit.
- Lane datapaths deliver per-lane predicate and active bits in lane-group beats, LANES_PER_BEAT lanes per cycle.
- This block assembles the full-warp predicate and active vectors with the instruction's vote op, warp id and destination register.
- It presents one complete vote request per instruction to the vote unit and writeback over a valid/ready handshake.

Parameters:
- WARP_SIZE, pkg_opengpu::WARP_SIZE (32): lanes per warp.
- LANES_PER_BEAT, 8: lanes delivered per input beat. Must divide WARP_SIZE; elaboration error otherwise.
- WARP_ID_WIDTH, 5: warp id width.
- REG_ADDR_WIDTH, 5: destination register index width.
- NUM_BEATS (localparam), WARP_SIZE/LANES_PER_BEAT: beats per instruction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous abort of any partial or held request
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_first  in  1  marks beat 0 of an instruction
- in_pred  in  LANES_PER_BEAT  predicate bits for the current lane group
- in_mask  in  LANES_PER_BEAT  active bits for the current lane group
- in_vote_op  in  vote_op_t  vote operation; sampled on the first beat only
- in_warp_id  in  WARP_ID_WIDTH  warp id; sampled on the first beat only
- in_rd  in  REG_ADDR_WIDTH  destination register; sampled on the first beat only
- out_valid  out  1  complete request available
- out_ready  in  1  consumer accepts
- out_predicate  out  WARP_SIZE  assembled predicate vector
- out_active_mask  out  WARP_SIZE  assembled active mask
- out_vote_op  out  vote_op_t  captured op
- out_warp_id  out  WARP_ID_WIDTH  captured warp id
- out_rd  out  REG_ADDR_WIDTH  captured destination register
- proto_err  out  1  one-cycle pulse on a beat-sequencing violation

Behaviour:
- Reset: state IDLE, beat counter 0, out_valid 0, proto_err 0.
- Reset values: all out_* data registers 0; out_vote_op = VOTE_ALL encoding 0.
- Lane mapping: accepted beat k writes lanes [k*LANES_PER_BEAT +: LANES_PER_BEAT] of both vectors.
- Lanes not yet written in the current instruction are cleared to 0 when beat 0 is accepted.
- States:
  - IDLE (no partial request)
  - COLLECT (1..NUM_BEATS-1 beats held)
  - HOLD (complete request presented)
- in_ready = (state != HOLD) || out_ready. This is combinational from out_ready only and allows back-to-back instructions.
- IDLE, beat accepted with in_first=1: write beat 0 and capture op/warp/rd. Go to COLLECT with count 1, or to HOLD if NUM_BEATS==1.
- IDLE, beat accepted with in_first=0: beat dropped; proto_err pulses next cycle; stay IDLE.
- COLLECT, beat accepted with in_first=0: write beat at the counter position and increment. On the last beat go to HOLD; out_valid rises the cycle after the last beat is accepted.
- COLLECT, beat accepted with in_first=1: discard the partial request, restart with this beat as beat 0 (new op/warp/rd), and pulse proto_err.
- HOLD: out_* are stable while out_valid & !out_ready. On out_valid & out_ready the next state is IDLE.
- HOLD with simultaneous first-beat acceptance: the next state is COLLECT with count 1, or HOLD with new data if NUM_BEATS==1.
- HOLD with an accepted beat that has in_first=0: the request is still released, the beat is dropped, and proto_err pulses.
- Latency: out_valid asserts 1 cycle after the final beat is accepted. Minimum instruction spacing is NUM_BEATS cycles.
- flush: next state IDLE, counter 0, out_valid 0; any same-cycle input beat is ignored. Reset has priority over flush; flush has priority over all other events.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro VOTE_COLLECT_PERF_EN.
- With the macro defined, two extra output ports are added:
  - perf_issued, 32 bits: count of out_valid & out_ready handshakes.
  - perf_errors, 32 bits: count of proto_err pulses.
- Both counters reset to 0 on rst, are not cleared by flush, and wrap modulo 2^32.
- Without the macro the ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- 4 beats, in_first only on beat 0:
  - pred 8'hFF,8'h0F,8'h00,8'hA5; mask all 8'hFF; op VOTE_BAL, warp 3, rd 7; out_ready=1.
  - Required: one cycle after beat 3, out_valid=1 with out_predicate=32'hA5000FFF, out_active_mask=32'hFFFFFFFF, warp 3, rd 7.
  - out_valid=0 the following cycle.
- Backpressure and overlap: hold out_ready=0 for 5 cycles after completion.
  - Required: in_ready=0 and out_* stable throughout.
  - Then raise out_ready with the next first beat valid: the handshake occurs and that beat is accepted in the same cycle.
- Restart: beats 0,1 accepted, then a beat with in_first=1 and pred 8'h01.
  - Required: proto_err pulses once; after 3 more beats the output holds only the new instruction's data (lane 0 = 1).
- Stray beat: in_first=0 in IDLE.
  - Required: proto_err pulses; no out_valid; the next correct instruction completes normally.
- flush asserted after beat 2, and separately during HOLD.
  - Required: out_valid=0 next cycle, state IDLE, no output produced.
- rst asserted mid-COLLECT with in_valid=1.
  - Required: all outputs 0 next cycle.
  - With VOTE_COLLECT_PERF_EN: perf_issued and perf_errors are 0 after reset and increment exactly once per handshake/error in the scenarios above.
